// File: rtl/rs_enc_16_8.sv
// Systematic RS(16,8) encoder over GF(256): message symbols pass through with one cycle
// of latency, followed by eight LFSR parity symbols emitted highest-order first.
module rs_enc_16_8 #(
    parameter int         N         = 16,
    parameter int         K         = 8,
    parameter logic [8:0] PRIM_POLY = 9'h11D
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       din_val,
    input  logic       din_sop,
    input  logic       din_eop,
    input  logic [7:0] din,
    output logic       din_rdy,
    output logic       dout_val,
    output logic       dout_sop,
    output logic       dout_eop,
    output logic [7:0] dout,
    output logic       frame_err
);
    localparam int NPAR = N - K;
    localparam int CW   = $clog2(K + 1);
    localparam int PW   = (NPAR > 1) ? $clog2(NPAR) : 1;

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] r;
        logic [7:0] sh;
        r  = '0;
        sh = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) r = r ^ sh;
            sh = sh[7] ? ({sh[6:0], 1'b0} ^ PRIM_POLY[7:0]) : {sh[6:0], 1'b0};
        end
        return r;
    endfunction

    // g(x) = prod_{i=1..8} (x + alpha^i), evaluated at elaboration; GEN[j] is coefficient of x^j.
    function automatic logic [8:0][7:0] gen_poly();
        logic [8:0][7:0] g;
        logic [7:0]      root;
        g    = '0;
        g[0] = 8'h01;
        root = 8'h01;
        for (int i = 1; i <= 8; i++) begin
            root = gf_mul(root, 8'h02);
            for (int j = 8; j >= 1; j--) g[j] = g[j-1] ^ gf_mul(g[j], root);
            g[0] = gf_mul(g[0], root);
        end
        return g;
    endfunction

    localparam logic [8:0][7:0] GEN = gen_poly();

    typedef enum logic [1:0] {IDLE, MSG, PARITY} state_t;

    state_t          state;
    logic [7:0][7:0] p;
    logic [CW-1:0]   count;
    logic [PW-1:0]   par_cnt;

    logic            accept;
    logic [7:0][7:0] seed;
    logic [7:0][7:0] p_next;
    logic [7:0]      fb;
    logic [CW-1:0]   cnt_next;

    assign din_rdy = (state != PARITY);
    assign accept  = din_val && din_rdy;

    // A start-of-frame symbol reseeds the register from zero, so a restart needs no extra cycle.
    always_comb begin
        seed      = din_sop ? '0 : p;
        fb        = din ^ seed[7];
        p_next    = '0;
        p_next[0] = gf_mul(fb, GEN[0]);
        for (int j = 1; j < 8; j++) p_next[j] = seed[j-1] ^ gf_mul(fb, GEN[j]);
        cnt_next  = din_sop ? CW'(1) : count + CW'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            p         <= '0;
            count     <= '0;
            par_cnt   <= '0;
            dout_val  <= 1'b0;
            dout_sop  <= 1'b0;
            dout_eop  <= 1'b0;
            dout      <= 8'h00;
            frame_err <= 1'b0;
        end else begin
            dout_val  <= 1'b0;
            dout_sop  <= 1'b0;
            dout_eop  <= 1'b0;
            dout      <= 8'h00;
            frame_err <= 1'b0;
            case (state)
                IDLE, MSG: begin
                    if (accept) begin
                        if (state == IDLE && !din_sop) begin
                            frame_err <= 1'b1;
                        end else begin
                            dout_val <= 1'b1;
                            dout_sop <= din_sop;
                            dout     <= din;
                            if (din_eop && cnt_next == CW'(K)) begin
                                p       <= p_next;
                                count   <= cnt_next;
                                par_cnt <= '0;
                                state   <= PARITY;
                            end else if (din_eop || cnt_next == CW'(K)) begin
                                frame_err <= 1'b1;
                                p         <= '0;
                                count     <= '0;
                                state     <= IDLE;
                            end else begin
                                p     <= p_next;
                                count <= cnt_next;
                                state <= MSG;
                            end
                        end
                    end
                end
                PARITY: begin
                    // Shifting toward p[7] leaves the register cleared after the last symbol.
                    dout_val <= 1'b1;
                    dout     <= p[7];
                    p        <= {p[6:0], 8'h00};
                    par_cnt  <= par_cnt + PW'(1);
                    if (par_cnt == PW'(NPAR - 1)) begin
                        dout_eop <= 1'b1;
                        count    <= '0;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/rs_enc_16_8.md
RS_ENC_16_8 -- requirements
Module: rs_enc_16_8

Interface
REQ-001 SHALL have parameter N, default 16, codeword length in symbols.
REQ-002 SHALL have parameter K, default 8, message length in symbols; N-K=8 parity symbols.
REQ-003 SHALL have parameter PRIM_POLY, default 9'h11D, GF(256) primitive polynomial.
REQ-004 SHALL have port clk, input, 1, single clock; all state on rising edge.
REQ-005 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-006 SHALL have port din_val, input, 1, input symbol valid.
REQ-007 SHALL have port din_sop, input, 1, first message symbol, qualified by din_val.
REQ-008 SHALL have port din_eop, input, 1, last message symbol, qualified by din_val.
REQ-009 SHALL have port din, input, 8, message symbol.
REQ-010 SHALL have port din_rdy, output, 1, encoder accepts input this cycle.
REQ-011 SHALL have port dout_val, output, 1, output symbol valid.
REQ-012 SHALL have port dout_sop, output, 1, first codeword symbol.
REQ-013 SHALL have port dout_eop, output, 1, last codeword symbol.
REQ-014 SHALL have port dout, output, 8, codeword symbol.
REQ-015 SHALL have port frame_err, output, 1, one-cycle pulse on malformed input frame.

Function
REQ-016 SHALL be systematic: codeword = K message symbols unchanged, followed by 8 parity symbols = remainder of m(x)*x^8 mod g(x).
REQ-017 SHALL use g(x) = product over i=1..8 of (x + alpha^i), alpha = 8'h02, GF(256) mod PRIM_POLY; coefficients g0..g7 are fixed constants derived from this product (g8=1).
REQ-018 SHALL hold an 8-stage x 8-bit LFSR p[0..7]; accepted symbol: fb = din ^ p[7]; p[j] <= p[j-1] ^ fb*g_j (p[-1]=0).
REQ-019 SHALL accept a symbol only when din_val && din_rdy; din_val while din_rdy=0 is ignored (no state change, no flag).
REQ-020 SHALL have FSM states IDLE, MSG, PARITY; din_rdy = 1 in IDLE and MSG, 0 in PARITY.
REQ-021 IDLE: accepted symbol with din_sop -> load LFSR from fb with p cleared first, msg count=1, go MSG; accepted symbol without din_sop -> drop, pulse frame_err.
REQ-022 MSG: accepted symbol increments count; din_eop with count reaching K -> go PARITY; din_eop with count != K, or count reaching K without din_eop -> pulse frame_err, clear LFSR, go IDLE, no parity emitted.
REQ-023 MSG: accepted din_sop restarts frame (LFSR reseeded, count=1), no frame_err; dout_sop re-emitted.
REQ-024 PARITY: exactly 8 cycles; each cycle load dout with p[7], shift p toward p[7] inserting 0; after 8th cycle go IDLE.
REQ-025 Message latency SHALL be 1 cycle: accepted symbol appears on dout next cycle with dout_val=1, dout_sop mirroring din_sop.
REQ-026 For eop accepted in cycle T: parity symbols on dout in cycles T+2..T+9 (highest-order first), dout_eop=1 only in T+9; din_rdy=0 in T+1..T+8.
REQ-027 dout_val SHALL be 0 in every cycle with no symbol; dout, dout_sop, dout_eop hold 0 when dout_val=0.
REQ-028 Sustained throughput SHALL be one codeword per 16 cycles, next sop accepted at T+9 earliest.
REQ-029 frame_err SHALL be registered, asserted the cycle after the offending accept.

Reset
REQ-030 On rst=1, immediately: state IDLE, LFSR=0, count=0, dout_val/dout_sop/dout_eop/frame_err/dout=0, din_rdy=1.
REQ-031 Reset mid-frame or mid-PARITY SHALL discard the frame; no dout_eop emitted after release.
REQ-032 First accept permitted in first rising edge with rst=0.

Verification
REQ-033 Eight zero symbols (sop on 1st, eop on 8th) -> dout 16 zeros, dout_sop at T-6, dout_eop at T+9, frame_err=0.
REQ-034 Message 00x7 then 01 -> parity T+2..T+9 equals g7,g6,..,g0; whole 16-symbol output evaluates to 0 at alpha^1..alpha^8.
REQ-035 Random messages back-to-back at max rate -> each codeword matches software model, zero syndromes at alpha^1..alpha^8, din_val during din_rdy=0 ignored.
REQ-036 eop on 5th symbol -> frame_err pulse next cycle, no parity, next sop encodes correctly.
REQ-037 rst pulsed at 4th parity cycle -> outputs 0 same cycle, no dout_eop, next frame correct.
REQ-038 sop on 3rd symbol of frame -> new frame restarts, 8 symbols from restart form correct codeword.
